tx_sched: RTL and testbench

Transmit-access scheduler for the wimpFi transmitter. Grants the single transmit path to one of two requesters (ACK, data frame) after the channel has been idle for the required inter-frame space, optionally followed by a random backoff. It drives `txen` into the transmit fail-safe and reacts to that block's `txen_fail` by aborting the grant.

---
 rtl/tx_sched_if.sv | 25 ++
 rtl/tx_sched.sv | 194 +++++++++++++++++++
 tb/tb_tx_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_sched_if.sv
// Handshake bundle between the transmit scheduler, its two requesters and the TX fail-safe.
// master: requesters/fail-safe side; slave: the scheduler itself.
interface tx_sched_if;
  logic bit_enb;
  logic cardet;
  logic req_ack;
  logic req_data;
  logic tx_done;
  logic txen_fail;
  logic txen;
  logic gnt_ack;
  logic gnt_data;
  logic abort;
  logic busy;

  modport master (
    output bit_enb, cardet, req_ack, req_data, tx_done, txen_fail,
    input  txen, gnt_ack, gnt_data, abort, busy
  );

  modport slave (
    input  bit_enb, cardet, req_ack, req_data, tx_done, txen_fail,
    output txen, gnt_ack, gnt_data, abort, busy
  );
endinterface

// File: rtl/tx_sched.sv
// tx_sched: grants the single transmit path to ACK or data after the inter-frame space.
// Define TX_SCHED_BACKOFF_EN to add the LFSR-driven random slot backoff for data frames.
module tx_sched #(
  parameter int DIFS_BITS = 80,
  parameter int SIFS_BITS = 16,
  parameter int SLOT_BITS = 8,
  parameter int CW_MAX    = 31
) (
  input  logic      clk,
  input  logic      rst,
  tx_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IFS, BACKOFF, TX, ABORT} state_t;

  localparam int IFS_MAX = (DIFS_BITS > SIFS_BITS) ? DIFS_BITS : SIFS_BITS;
  localparam int IFS_W   = $clog2(IFS_MAX + 1);
  localparam logic [IFS_W-1:0] DIFS_LD = IFS_W'(DIFS_BITS);
  localparam logic [IFS_W-1:0] SIFS_LD = IFS_W'(SIFS_BITS);
  localparam logic [IFS_W-1:0] IFS_ONE = IFS_W'(1);

  if (DIFS_BITS < 1 || SIFS_BITS < 1 || SLOT_BITS < 1 || CW_MAX < 0 || CW_MAX > 255) begin : g_bad_params
    $error("tx_sched: parameter out of range");
  end

  state_t           state;
  logic             owner_ack;
  logic [IFS_W-1:0] ifs_cnt;
  logic             txen_q, gnt_ack_q, gnt_data_q, abort_q, busy_q;
  logic             own_req, chan_idle_bit, chan_busy_bit;

  assign own_req       = owner_ack ? bus.req_ack : bus.req_data;
  assign chan_idle_bit = bus.bit_enb & ~bus.cardet;
  assign chan_busy_bit = bus.bit_enb &  bus.cardet;

`ifdef TX_SCHED_BACKOFF_EN
  localparam int SLOT_W = $clog2(SLOT_BITS + 1);
  localparam int CW_W   = (CW_MAX > 0) ? $clog2(CW_MAX + 1) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LD  = SLOT_W'(SLOT_BITS);
  localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
  localparam logic [CW_W-1:0]   CW_ONE   = CW_W'(1);
  localparam logic [7:0]        CW_MASK  = 8'(CW_MAX);

  logic [7:0]        lfsr;
  logic [CW_W-1:0]   slot_cnt, slot_draw;
  logic [SLOT_W-1:0] bit_cnt;
  logic              drawn;

  assign slot_draw = CW_W'(lfsr & CW_MASK);

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; the nonzero seed keeps it off the all-zero lock-up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_ack  <= 1'b0;
      ifs_cnt    <= '0;
      txen_q     <= 1'b0;
      gnt_ack_q  <= 1'b0;
      gnt_data_q <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TX_SCHED_BACKOFF_EN
      slot_cnt   <= '0;
      bit_cnt    <= '0;
      drawn      <= 1'b0;
`endif
    end else begin
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_ack || bus.req_data) begin
            state     <= IFS;
            owner_ack <= bus.req_ack;
            ifs_cnt   <= bus.req_ack ? SIFS_LD : DIFS_LD;
            busy_q    <= 1'b1;
          end
        end
        IFS: begin
          if (!own_req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
`ifdef TX_SCHED_BACKOFF_EN
            drawn  <= 1'b0;
`endif
          end else if (!owner_ack && bus.req_ack) begin
            owner_ack <= 1'b1;
            ifs_cnt   <= SIFS_LD;
`ifdef TX_SCHED_BACKOFF_EN
            drawn     <= 1'b0;
`endif
          end else if (chan_busy_bit) begin
            ifs_cnt <= owner_ack ? SIFS_LD : DIFS_LD;
          end else if (chan_idle_bit) begin
            if (ifs_cnt > IFS_ONE) begin
              ifs_cnt <= ifs_cnt - 1'b1;
            end else begin
              ifs_cnt <= '0;
`ifdef TX_SCHED_BACKOFF_EN
              // A data frame resumes any slots left from an interrupted backoff before drawing anew.
              if (!owner_ack && drawn) begin
                state   <= BACKOFF;
                bit_cnt <= SLOT_LD;
              end else if (!owner_ack && slot_draw != '0) begin
                state    <= BACKOFF;
                bit_cnt  <= SLOT_LD;
                slot_cnt <= slot_draw;
                drawn    <= 1'b1;
              end else begin
`endif
                state      <= TX;
                txen_q     <= 1'b1;
                gnt_ack_q  <= owner_ack;
                gnt_data_q <= ~owner_ack;
`ifdef TX_SCHED_BACKOFF_EN
              end
`endif
            end
          end
        end
`ifdef TX_SCHED_BACKOFF_EN
        BACKOFF: begin
          if (!bus.req_data) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            drawn  <= 1'b0;
          end else if (bus.req_ack) begin
            state     <= IFS;
            owner_ack <= 1'b1;
            ifs_cnt   <= SIFS_LD;
            drawn     <= 1'b0;
          end else if (chan_busy_bit) begin
            state   <= IFS;
            ifs_cnt <= DIFS_LD;
          end else if (chan_idle_bit) begin
            if (bit_cnt > SLOT_ONE) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              bit_cnt <= SLOT_LD;
              if (slot_cnt > CW_ONE) begin
                slot_cnt <= slot_cnt - 1'b1;
              end else begin
                slot_cnt   <= '0;
                drawn      <= 1'b0;
                state      <= TX;
                txen_q     <= 1'b1;
                gnt_data_q <= 1'b1;
              end
            end
          end
        end
`endif
        TX: begin
          if (bus.txen_fail) begin
            state      <= ABORT;
            txen_q     <= 1'b0;
            gnt_ack_q  <= 1'b0;
            gnt_data_q <= 1'b0;
            abort_q    <= 1'b1;
          end else if (bus.tx_done) begin
            state      <= IDLE;
            txen_q     <= 1'b0;
            gnt_ack_q  <= 1'b0;
            gnt_data_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        ABORT: begin
          if (!bus.txen_fail) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          txen_q     <= 1'b0;
          gnt_ack_q  <= 1'b0;
          gnt_data_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.txen     = txen_q;
  assign bus.gnt_ack  = gnt_ack_q;
  assign bus.gnt_data = gnt_data_q;
  assign bus.abort    = abort_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched: directed scenario tasks plus a randomized run against a behavioural model.
module tb_tx_sched;
  localparam int DIFS = 4;
  localparam int SIFS = 2;
  localparam int SLOT = 2;
  localparam int CW   = 7;

  localparam int M_IDLE  = 0;
  localparam int M_IFS   = 1;
  localparam int M_SLOT  = 2;
  localparam int M_TX    = 3;
  localparam int M_ABORT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tx_sched_if bus ();

  tx_sched #(
    .DIFS_BITS(DIFS),
    .SIFS_BITS(SIFS),
    .SLOT_BITS(SLOT),
    .CW_MAX   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  // Behavioural reference: which phase the channel access is in, and what is still owed.
  int         m_mode;
  bit         m_ack;
  int         m_need;
  int         m_slots;
  int         m_slot_bits;
  bit         m_abort;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  function automatic logic [4:0] outs();
    return {bus.txen, bus.gnt_ack, bus.gnt_data, bus.abort, bus.busy};
  endfunction

  function automatic logic [4:0] exp_out();
    return {m_mode == M_TX, (m_mode == M_TX) && m_ack, (m_mode == M_TX) && !m_ack,
            m_abort, m_mode != M_IDLE};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ack = 1'b0; m_need = 0; m_slots = 0; m_slot_bits = 0;
    m_abort = 1'b0; m_lfsr = 8'hA5;
  endtask

  task automatic model_step();
    logic [7:0] cur;
    cur = m_lfsr;
    m_abort = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (bus.req_ack || bus.req_data) begin
          m_mode = M_IFS;
          m_ack  = bus.req_ack;
          m_need = bus.req_ack ? SIFS : DIFS;
        end
      end
      M_IFS, M_SLOT: begin
        if (!(m_ack ? bus.req_ack : bus.req_data)) begin
          m_mode = M_IDLE; m_slots = 0;
        end else if (!m_ack && bus.req_ack) begin
          m_mode = M_IFS; m_ack = 1'b1; m_need = SIFS; m_slots = 0;
        end else if (bus.bit_enb && bus.cardet) begin
          m_mode = M_IFS; m_need = m_ack ? SIFS : DIFS;
        end else if (bus.bit_enb) begin
          if (m_mode == M_IFS) begin
            m_need = m_need - 1;
            if (m_need == 0) begin
              if (m_ack) m_mode = M_TX;
              else begin
`ifdef TX_SCHED_BACKOFF_EN
                if (m_slots == 0) m_slots = int'(cur & 8'(CW));
                if (m_slots == 0) m_mode = M_TX;
                else begin m_mode = M_SLOT; m_slot_bits = 0; end
`else
                m_mode = M_TX;
`endif
              end
            end
          end else begin
            m_slot_bits = m_slot_bits + 1;
            if (m_slot_bits == SLOT) begin
              m_slot_bits = 0;
              m_slots = m_slots - 1;
              if (m_slots == 0) m_mode = M_TX;
            end
          end
        end
      end
      M_TX: begin
        if (bus.txen_fail) begin m_mode = M_ABORT; m_abort = 1'b1; end
        else if (bus.tx_done) m_mode = M_IDLE;
      end
      M_ABORT: if (!bus.txen_fail) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.bit_enb = 1'b0; bus.cardet = 1'b0; bus.req_ack = 1'b0;
    bus.req_data = 1'b0; bus.tx_done = 1'b0; bus.txen_fail = 1'b0;
  endtask

  task automatic pulse_bit(input logic busy_chan);
    bus.bit_enb = 1'b1; bus.cardet = busy_chan;
    tick();
    bus.bit_enb = 1'b0; bus.cardet = 1'b0;
  endtask

  // Idle until the LFSR value the DUT will sample on the next edge yields the wanted slot draw.
  task automatic wait_draw(input int want);
    int n;
    n = 0;
    while (int'(m_lfsr & 8'(CW)) != want && n < 600) begin
      tick();
      n++;
    end
    total++;
    if (int'(m_lfsr & 8'(CW)) != want)
      $display("FAIL wait_draw: lfsr draw %0d never reached required %0d", m_lfsr & 8'(CW), want);
    else passed++;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick(); tick();
    total++;
    if (outs() !== 5'b00000) $display("FAIL reset_outs: got %b want %b", outs(), 5'b00000);
    else passed++;
`ifdef TX_SCHED_BACKOFF_EN
    total++;
    if (dut.lfsr !== 8'hA5) $display("FAIL reset_lfsr: got %h want %h", dut.lfsr, 8'hA5);
    else passed++;
`endif
    rst = 1'b1;
    tick();
    total++;
    if (outs() !== 5'b00000) $display("FAIL idle_after_reset: got %b want %b", outs(), 5'b00000);
    else passed++;
  endtask

  task automatic test_data_difs();
    bus.req_data = 1'b1;
    tick();
    total++;
    if (outs() !== 5'b00001) $display("FAIL data_accept: got %b want %b", outs(), 5'b00001);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      pulse_bit(1'b0);
      total++;
      if (outs() !== 5'b00001) $display("FAIL data_difs_bit%0d: got %b want %b", i, outs(), 5'b00001);
      else passed++;
      tick();
    end
    wait_draw(0);
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b10101) $display("FAIL data_grant: got %b want %b", outs(), 5'b10101);
    else passed++;
    tick();
    total++;
    if (outs() !== 5'b10101) $display("FAIL data_grant_hold: got %b want %b", outs(), 5'b10101);
    else passed++;
    bus.tx_done = 1'b1; bus.req_data = 1'b0;
    tick();
    bus.tx_done = 1'b0;
    total++;
    if (outs() !== 5'b00000) $display("FAIL data_done: got %b want %b", outs(), 5'b00000);
    else passed++;
  endtask

  task automatic test_ack_priority();
    bus.req_ack = 1'b1; bus.req_data = 1'b1;
    tick();
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b00001) $display("FAIL ack_sifs_bit1: got %b want %b", outs(), 5'b00001);
    else passed++;
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b11001) $display("FAIL ack_grant: got %b want %b", outs(), 5'b11001);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      pulse_bit(1'b0);
      total++;
      if (outs() !== 5'b11001) $display("FAIL ack_hold%0d: got %b want %b", i, outs(), 5'b11001);
      else passed++;
    end
    bus.tx_done = 1'b1; bus.req_ack = 1'b0;
    tick();
    bus.tx_done = 1'b0;
    total++;
    if (outs() !== 5'b00000) $display("FAIL ack_done: got %b want %b", outs(), 5'b00000);
    else passed++;
    tick();
    total++;
    if (outs() !== 5'b00001) $display("FAIL data_after_ack: got %b want %b", outs(), 5'b00001);
    else passed++;
    for (int i = 0; i < 3; i++) pulse_bit(1'b0);
    wait_draw(0);
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b10101) $display("FAIL data_after_ack_grant: got %b want %b", outs(), 5'b10101);
    else passed++;
    bus.tx_done = 1'b1; bus.req_data = 1'b0;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic test_cardet_reload();
    bus.req_data = 1'b1;
    tick();
    pulse_bit(1'b0);
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    total++;
    if (outs() !== 5'b00001) $display("FAIL cardet_busy_bit: got %b want %b", outs(), 5'b00001);
    else passed++;
    bus.cardet = 1'b1;
    tick();
    bus.cardet = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pulse_bit(1'b0);
      total++;
      if (outs() !== 5'b00001) $display("FAIL reload_bit%0d: got %b want %b", i, outs(), 5'b00001);
      else passed++;
    end
    wait_draw(0);
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b10101) $display("FAIL reload_grant: got %b want %b", outs(), 5'b10101);
    else passed++;
    bus.tx_done = 1'b1; bus.req_data = 1'b0;
    tick();
    bus.tx_done = 1'b0;
  endtask

`ifdef TX_SCHED_BACKOFF_EN
  task automatic test_backoff();
    bus.req_data = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pulse_bit(1'b0);
    wait_draw(3);
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b00001) $display("FAIL backoff_enter: got %b want %b", outs(), 5'b00001);
    else passed++;
    pulse_bit(1'b0);
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    for (int i = 1; i <= 4; i++) begin
      pulse_bit(1'b0);
      total++;
      if (outs() !== 5'b00001) $display("FAIL backoff_difs%0d: got %b want %b", i, outs(), 5'b00001);
      else passed++;
    end
    for (int i = 1; i <= 3; i++) begin
      pulse_bit(1'b0);
      total++;
      if (outs() !== 5'b00001) $display("FAIL backoff_slotbit%0d: got %b want %b", i, outs(), 5'b00001);
      else passed++;
    end
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b10101) $display("FAIL backoff_grant: got %b want %b", outs(), 5'b10101);
    else passed++;
    bus.tx_done = 1'b1; bus.req_data = 1'b0;
    tick();
    bus.tx_done = 1'b0;
  endtask
`endif

  task automatic test_abort();
    bus.req_ack = 1'b1;
    tick();
    pulse_bit(1'b0);
    pulse_bit(1'b0);
    bus.txen_fail = 1'b1; bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0; bus.req_ack = 1'b0;
    total++;
    if (outs() !== 5'b00011) $display("FAIL abort_entry: got %b want %b", outs(), 5'b00011);
    else passed++;
    for (int i = 2; i <= 5; i++) begin
      tick();
      total++;
      if (outs() !== 5'b00001) $display("FAIL abort_hold%0d: got %b want %b", i, outs(), 5'b00001);
      else passed++;
    end
    bus.txen_fail = 1'b0;
    tick();
    total++;
    if (outs() !== 5'b00000) $display("FAIL abort_exit: got %b want %b", outs(), 5'b00000);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bus.req_ack = 1'b1;
    tick();
    pulse_bit(1'b0);
    pulse_bit(1'b0);
    total++;
    if (outs() !== 5'b11001) $display("FAIL mid_pre_grant: got %b want %b", outs(), 5'b11001);
    else passed++;
    #2 rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (outs() !== 5'b00000) $display("FAIL mid_reset_async: got %b want %b", outs(), 5'b00000);
    else passed++;
    bus.req_ack = 1'b0;
    tick();
    rst = 1'b1;
`ifdef TX_SCHED_BACKOFF_EN
    total++;
    if (dut.lfsr !== 8'hA5) $display("FAIL mid_reset_lfsr: got %h want %h", dut.lfsr, 8'hA5);
    else passed++;
    tick();
    total++;
    if (dut.lfsr !== lfsr_next(8'hA5))
      $display("FAIL lfsr_step: got %h want %h", dut.lfsr, lfsr_next(8'hA5));
    else passed++;
`else
    tick();
`endif
    total++;
    if (outs() !== 5'b00000) $display("FAIL mid_reset_idle: got %b want %b", outs(), 5'b00000);
    else passed++;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.bit_enb = ($urandom_range(0, 2) == 0);
      bus.cardet  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bus.req_ack  = ~bus.req_ack;
      if ($urandom_range(0, 11) == 0) bus.req_data = ~bus.req_data;
      bus.tx_done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) bus.txen_fail = ~bus.txen_fail;
      tick();
      total++;
      if (outs() !== exp_out())
        $display("FAIL rand_cyc%0d: got %b want %b", cyc, outs(), exp_out());
      else passed++;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d of %0d checks done", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_inputs();
    test_reset();
    test_data_difs();
    test_ack_priority();
    test_cardet_reload();
`ifdef TX_SCHED_BACKOFF_EN
    test_backoff();
`endif
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
